// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// The ops and FSM states are common to the interface, the top and the step logic.
package muldiv_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [2:0] {
    MDU_IDLE,
    MDU_PREP,
    MDU_ITER,
    MDU_FIXUP,
    MDU_DONE
  } mdu_state_t;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Decode-side request/response bundle of the multiply/divide unit.
// The master is the pipeline (decode/execute), the slave is muldiv_ctrl.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic            start;
  mdu_op_t         op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            freeze_ex;
  logic            done;
  logic [XLEN-1:0] hi_out;
  logic [XLEN-1:0] lo_out;

  modport master (
    output start, op, rs_val, rt_val, flush,
    input  freeze_ex, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush,
    output freeze_ex, done, hi_out, lo_out
  );

endinterface

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// In divide mode acc holds {remainder, dividend/quotient} and mplier holds the divisor.
module mdu_iter_step
  import muldiv_ctrl_pkg::*;
(
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [2*XLEN-1:0] mcand_i,
  input  logic [XLEN-1:0]   mplier_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [2*XLEN-1:0] mcand_o,
  output logic [XLEN-1:0]   mplier_o
);

  logic [XLEN:0]   partial;
  logic            ge;
  logic [XLEN-1:0] diff;

  always_comb begin
    acc_o    = acc_i;
    mcand_o  = mcand_i;
    mplier_o = mplier_i;
    // Shifted remainder with the next dividend bit; the top bit can exceed XLEN bits.
    partial  = acc_i[2*XLEN-1:XLEN-1];
    ge       = partial >= {1'b0, mplier_i};
    diff     = partial[XLEN-1:0] - mplier_i;
    if (is_div_i) begin
      acc_o = {(ge ? diff : partial[XLEN-1:0]), acc_i[XLEN-2:0], ge};
    end else begin
      if (mplier_i[0]) begin
        acc_o = acc_i + mcand_i;
      end
      mcand_o  = mcand_i << 1;
      mplier_o = mplier_i >> 1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: FSM, iteration counter, sign flags and the HI/LO registers.
// Optional MDU_EARLY_OUT_EN: multiply leaves ITER once the shifted multiplier is zero.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  muldiv_ctrl_if.slave bus
);

  mdu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mdu_op_t           op_q, op_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic              is_signed, is_div, last;
  logic [2*XLEN-1:0] step_acc, step_mcand;
  logic [XLEN-1:0]   step_mplier;

  assign is_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
  assign is_div    = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

  mdu_iter_step u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (step_acc),
    .mcand_o  (step_mcand),
    .mplier_o (step_mplier)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    last      = 1'b0;
    unique case (state_q)
      MDU_IDLE: begin
        // Raw operands are captured here; PREP converts them to magnitudes.
        if (bus.start && !bus.flush) begin
          state_d  = MDU_PREP;
          op_d     = bus.op;
          mcand_d  = {{XLEN{1'b0}}, bus.rs_val};
          mplier_d = bus.rt_val;
        end
      end
      MDU_PREP: begin
        neg_res_d = is_signed && (mcand_q[XLEN-1] ^ mplier_q[XLEN-1]);
        neg_rem_d = is_signed && mcand_q[XLEN-1];
        mplier_d  = abs_val(mplier_q, is_signed);
        cnt_d     = CNT_W'(XLEN);
        state_d   = MDU_ITER;
        if (is_div) begin
          acc_d = {{XLEN{1'b0}}, abs_val(mcand_q[XLEN-1:0], is_signed)};
          if (mplier_q == '0) begin
            hi_d    = mcand_q[XLEN-1:0];
            lo_d    = '1;
            state_d = MDU_DONE;
          end
        end else begin
          acc_d   = '0;
          mcand_d = {{XLEN{1'b0}}, abs_val(mcand_q[XLEN-1:0], is_signed)};
        end
      end
      MDU_ITER: begin
        acc_d    = step_acc;
        mcand_d  = step_mcand;
        mplier_d = step_mplier;
        cnt_d    = cnt_q - CNT_W'(1);
        last     = (cnt_d == '0);
`ifdef MDU_EARLY_OUT_EN
        if (!is_div && (step_mplier == '0)) begin
          last = 1'b1;
        end
`endif
        if (last) begin
          state_d = MDU_FIXUP;
        end
      end
      MDU_FIXUP: begin
        // HI/LO become architectural on the edge into DONE, so done and data coincide.
        if (is_div) begin
          lo_d = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
          hi_d = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        end else begin
          {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
        end
        state_d = MDU_DONE;
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (bus.flush && (state_q inside {MDU_PREP, MDU_ITER, MDU_FIXUP})) begin
      state_d = MDU_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      op_q      <= MDU_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.freeze_ex = ((state_q == MDU_IDLE) && bus.start) ||
                         ((state_q != MDU_IDLE) && (state_q != MDU_DONE));
  assign bus.done      = (state_q == MDU_DONE);
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;

endmodule
